bus_rr_arbiter: RTL and testbench

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

---
 rtl/bus_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_bus_rr_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter granting one of NMASTERS bus masters access to a single slave port.
// Optional BUSY watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_rr_arbiter #(
    parameter int NMASTERS       = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [32*NMASTERS-1:0] master_address,
    input  logic [32*NMASTERS-1:0] master_data_i,
    input  logic [4*NMASTERS-1:0]  master_wr,
    input  logic [NMASTERS-1:0]    master_enable,
    output logic [31:0]            master_data_o,
    output logic [NMASTERS-1:0]    master_ready,
    output logic [NMASTERS-1:0]    master_error,
    input  logic [31:0]            slave_data_i,
    input  logic                   slave_ready,
    input  logic                   slave_error,
    output logic [31:0]            slave_address,
    output logic [31:0]            slave_data_o,
    output logic [3:0]             slave_wr,
    output logic                   slave_enable
);

    localparam int GW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic            timeout;
    logic            found;
    int unsigned     idx;

`ifdef BUS_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    assign timeout = (state_q == BUSY) && (cnt_q == 16'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            if (state_d == BUSY) cnt_d = '0;
        end else if (!slave_ready && !slave_error) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    assign master_data_o = slave_data_i;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        found        = 1'b0;
        idx          = 0;

        slave_address = '0;
        slave_data_o  = '0;
        slave_wr      = '0;
        slave_enable  = 1'b0;
        master_ready  = '0;
        master_error  = '0;

        case (state_q)
            IDLE: begin
                // Scan starts just past the previous winner so each master gets a turn
                for (int unsigned k = 1; k <= NMASTERS; k++) begin
                    idx = (int'(last_grant_q) + k) % NMASTERS;
                    if (!found && master_enable[idx]) begin
                        found   = 1'b1;
                        grant_d = GW'(idx);
                    end
                end
                if (found) state_d = BUSY;
            end
            BUSY: begin
                slave_address = master_address[32*int'(grant_q) +: 32];
                slave_data_o  = master_data_i[32*int'(grant_q) +: 32];
                slave_wr      = master_wr[4*int'(grant_q) +: 4];
                slave_enable  = master_enable[grant_q] & ~timeout;

                // Error outranks ready; a watchdog expiry swallows a late ready
                master_error[grant_q] = slave_error | timeout;
                master_ready[grant_q] = slave_ready & ~slave_error & ~timeout;

                if (slave_ready || slave_error || timeout || !master_enable[grant_q]) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NMASTERS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: directed scenarios then random traffic,
// every cycle compared against a transaction-level reference model.
module tb_bus_rr_arbiter;

    localparam int N  = 3;
    localparam int TO = 4;
`ifdef BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [32*N-1:0] master_address;
    logic [32*N-1:0] master_data_i;
    logic [4*N-1:0]  master_wr;
    logic [N-1:0]    master_enable;
    logic [31:0]     master_data_o;
    logic [N-1:0]    master_ready;
    logic [N-1:0]    master_error;
    logic [31:0]     slave_data_i;
    logic            slave_ready;
    logic            slave_error;
    logic [31:0]     slave_address;
    logic [31:0]     slave_data_o;
    logic [3:0]      slave_wr;
    logic            slave_enable;

    int ncmp = 0;
    int nerr = 0;

    // Reference model state
    bit m_busy;
    int m_grant;
    int m_last;
    int m_cnt;

    bus_rr_arbiter #(.NMASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .master_address (master_address),
        .master_data_i  (master_data_i),
        .master_wr      (master_wr),
        .master_enable  (master_enable),
        .master_data_o  (master_data_o),
        .master_ready   (master_ready),
        .master_error   (master_error),
        .slave_data_i   (slave_data_i),
        .slave_ready    (slave_ready),
        .slave_error    (slave_error),
        .slave_address  (slave_address),
        .slave_data_o   (slave_data_o),
        .slave_wr       (slave_wr),
        .slave_enable   (slave_enable)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] en);
        for (int k = 1; k <= N; k++) begin
            if (en[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic bit timed_out();
        return TO_EN && m_busy && (m_cnt == TO);
    endfunction

    task automatic check_outputs();
        logic [31:0]  e_sa, e_sd;
        logic [3:0]   e_wr;
        logic         e_en;
        logic [N-1:0] e_mr, e_me;
        e_sa = '0; e_sd = '0; e_wr = '0; e_en = 1'b0; e_mr = '0; e_me = '0;
        if (m_busy) begin
            e_sa = master_address[32*m_grant +: 32];
            e_sd = master_data_i[32*m_grant +: 32];
            e_wr = master_wr[4*m_grant +: 4];
            e_en = master_enable[m_grant] && !timed_out();
            if (slave_error || timed_out()) e_me[m_grant] = 1'b1;
            else if (slave_ready)          e_mr[m_grant] = 1'b1;
        end
        chk("slave_address", slave_address, e_sa);
        chk("slave_data_o", slave_data_o, e_sd);
        chk("slave_wr", 32'(slave_wr), 32'(e_wr));
        chk("slave_enable", 32'(slave_enable), 32'(e_en));
        chk("master_ready", 32'(master_ready), 32'(e_mr));
        chk("master_error", 32'(master_error), 32'(e_me));
        chk("master_data_o", master_data_o, slave_data_i);
    endtask

    task automatic model_update();
        int g;
        if (rst) begin
            m_busy = 1'b0; m_last = N - 1; m_cnt = 0; m_grant = 0;
        end else if (!m_busy) begin
            g = rr_pick(m_last, master_enable);
            if (g >= 0) begin
                m_busy = 1'b1; m_grant = g; m_cnt = 0;
            end
        end else if (timed_out() || slave_ready || slave_error || !master_enable[m_grant]) begin
            m_busy = 1'b0; m_last = m_grant;
        end else begin
            m_cnt++;
        end
    endtask

    // Inputs are driven at the falling edge; outputs checked just after, state advances on the rising edge
    task automatic cyc();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_m(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        master_address[32*i +: 32] = a;
        master_data_i[32*i +: 32]  = d;
        master_wr[4*i +: 4]        = w;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        master_address = '0; master_data_i = '0; master_wr = '0; master_enable = '0;
        slave_data_i = '0; slave_ready = 1'b0; slave_error = 1'b0;
        m_busy = 1'b0; m_grant = 0; m_last = N - 1; m_cnt = 0;
        @(posedge clk);
        @(negedge clk);

        // Reset state, with slave_data_i passing through
        slave_data_i = 32'h5A5A_0001;
        cyc();
        #1;
        chk("rst_ready", 32'(master_ready), 32'd0);
        chk("rst_sen", 32'(slave_enable), 32'd0);
        rst = 1'b0;

        // Master1 read of 0x10, slave ready after two BUSY cycles
        set_m(1, 32'h0000_0010, 32'h0, 4'b0000);
        master_enable = 3'b010;
        #1; chk("s1_idle_sen", 32'(slave_enable), 32'd0);
        cyc();
        #1; chk("s1_sen_rise", 32'(slave_enable), 32'd1);
        chk("s1_addr", slave_address, 32'h0000_0010);
        cyc();
        slave_ready = 1'b1; slave_data_i = 32'hDEAD_BEEF;
        #1; chk("s1_ready", 32'(master_ready), 32'b010);
        chk("s1_rdata", master_data_o, 32'hDEAD_BEEF);
        cyc();
        slave_ready = 1'b0; master_enable = '0;
        #1; chk("s1_ready_drop", 32'(master_ready), 32'd0);
        cyc();

        // All three masters requesting: grants rotate with an IDLE gap between them
        do_reset();
        for (int i = 0; i < N; i++) set_m(i, 32'h100 * (i + 1), 32'h11 * (i + 1), 4'(i + 1));
        master_enable = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1; chk("rr_idle_gap", 32'(slave_enable), 32'd0);
            cyc();
            cyc();
            slave_ready = 1'b1;
            #1; chk("rr_order", 32'(master_ready), 32'(3'b001 << (k % 3)));
            cyc();
            slave_ready = 1'b0;
        end
        master_enable = '0;
        cyc();

        // Master2 write answered with ready and error together: error wins
        do_reset();
        set_m(2, 32'h1000_0004, 32'hCAFE_F00D, 4'b1111);
        master_enable = 3'b100;
        cyc();
        #1; chk("s3_wr", 32'(slave_wr), 32'hF);
        chk("s3_wdata", slave_data_o, 32'hCAFE_F00D);
        cyc();
        slave_ready = 1'b1; slave_error = 1'b1;
        #1; chk("s3_error", 32'(master_error), 32'b100);
        chk("s3_ready", 32'(master_ready), 32'b000);
        cyc();
        slave_ready = 1'b0; slave_error = 1'b0; master_enable = '0;
        cyc();

        // Slave never answers
        do_reset();
        set_m(0, 32'h0000_0200, 32'h0, 4'b0000);
        master_enable = 3'b001;
        cyc();
`ifdef BUS_TIMEOUT_EN
        repeat (4) cyc();
        slave_ready = 1'b1;
        #1; chk("to_error", 32'(master_error), 32'b001);
        chk("to_ready_ignored", 32'(master_ready), 32'd0);
        chk("to_sen_forced", 32'(slave_enable), 32'd0);
        cyc();
        slave_ready = 1'b0; master_enable = '0;
        #1; chk("to_idle", 32'(slave_enable), 32'd0);
        cyc();
`else
        repeat (1000) cyc();
        #1; chk("no_to_still_busy", 32'(slave_enable), 32'd1);
        master_enable = '0;
        cyc();
        cyc();
`endif

        // Reset in the 2nd BUSY cycle of master1, then masters 0 and 1 request
        do_reset();
        set_m(0, 32'h0000_0A00, 32'h0, 4'b0000);
        set_m(1, 32'h0000_0B00, 32'h0, 4'b0000);
        master_enable = 3'b010;
        cyc();
        cyc();
        rst = 1'b1;
        #1; chk("s5_no_pulse", 32'(master_ready | master_error), 32'd0);
        cyc();
        rst = 1'b0; master_enable = 3'b011;
        #1; chk("s5_after_rst_idle", 32'(slave_enable), 32'd0);
        cyc();
        #1; chk("s5_master0_first", slave_address, 32'h0000_0A00);
        slave_ready = 1'b1;
        cyc();
        slave_ready = 1'b0; master_enable = 3'b000;
        cyc();

        // Master0 aborts mid-BUSY; master1 is next
        do_reset();
        master_enable = 3'b011;
        cyc();
        cyc();
        master_enable = 3'b010;
        #1; chk("s6_abort_no_pulse", 32'(master_ready | master_error), 32'd0);
        cyc();
        #1; chk("s6_idle", 32'(slave_enable), 32'd0);
        cyc();
        #1; chk("s6_master1_next", slave_address, 32'h0000_0B00);
        slave_ready = 1'b1;
        cyc();
        slave_ready = 1'b0; master_enable = '0;
        cyc();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            master_enable = 3'($urandom);
            for (int i = 0; i < N; i++) set_m(i, $urandom, $urandom, 4'($urandom));
            slave_data_i = $urandom;
            slave_ready  = ($urandom_range(0, 3) == 0);
            slave_error  = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
